// File: rtl/mem_map_ws_if.sv
// Request/response bus between a master and the mem_map_ws memory map.
interface mem_map_ws_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] wd;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] rd;
  logic              ready;
  logic              err;

  modport master (output req, we, a, wd, be, input rd, ready, err);
  modport slave  (input req, we, a, wd, be, output rd, ready, err);
endinterface

// File: rtl/mem_map_ws.sv
// Memory map with wait states: word RAM at 0, writable output registers and
// synchronised read-only input words at IO_BASE, bus error on bad accesses.
module mem_map_ws #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] IO_BASE   = 32'h0000_1000,
  parameter int                N_OUT     = 4,
  parameter int                N_IN      = 2,
  parameter int                WAIT      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_map_ws_if.slave             bus,
  output logic [N_OUT*DATA_W-1:0] io_out,
  input  logic [N_IN*DATA_W-1:0]  io_in
);
  localparam int                BE_W     = DATA_W / 8;
  localparam int                OFF_W    = $clog2(BE_W);
  localparam int                RAM_AW   = $clog2(RAM_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);
  localparam logic [ADDR_W-1:0] RAM_END  = ADDR_W'(RAM_WORDS * BE_W);
  localparam logic [ADDR_W-1:0] IO_END   = IO_BASE + ADDR_W'(BE_W * (N_OUT + N_IN));

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAITING = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       a_q;
  logic [DATA_W-1:0]       wd_q;
  logic [BE_W-1:0]         be_q;
  logic [DATA_W-1:0]       rd_q;
  logic                    ready_q;
  logic                    err_q;
  logic [N_OUT*DATA_W-1:0] io_out_q;
  logic [N_IN*DATA_W-1:0]  sync1_q;
  logic [N_IN*DATA_W-1:0]  sync2_q;
  logic [DATA_W-1:0]       ram_q [RAM_WORDS];

  logic [ADDR_W-1:0] cur_a_s;
  logic              cur_we_s;
  logic              ram_hit_s;
  logic              io_hit_s;
  logic [ADDR_W-1:0] io_off_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic              err_s;
  logic              commit_s;
  logic [DATA_W-1:0] rdata_s;

  // Decode: in IDLE the live bus is decoded so a zero-wait access can respond at once.
  always_comb begin
    cur_a_s   = (state_q == S_IDLE) ? bus.a  : a_q;
    cur_we_s  = (state_q == S_IDLE) ? bus.we : we_q;
    ram_hit_s = (cur_a_s < RAM_END);
    io_hit_s  = (cur_a_s >= IO_BASE) && (cur_a_s < IO_END);
    io_off_s  = (cur_a_s - IO_BASE) >> OFF_W;
    ram_idx_s = RAM_AW'(cur_a_s >> OFF_W);
    err_s     = (|(cur_a_s & OFF_MASK)) || !(ram_hit_s || io_hit_s) ||
                (cur_we_s && io_hit_s && (io_off_s >= ADDR_W'(N_OUT)));
    commit_s  = (state_q == S_RESP) && we_q && !err_q;
    rdata_s   = '0;
    if (ram_hit_s) begin
      rdata_s = ram_q[ram_idx_s];
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        rdata_s = (io_off_s == ADDR_W'(i)) ? io_out_q[i*DATA_W +: DATA_W] : rdata_s;
      end
      for (int k = 0; k < N_IN; k++) begin
        rdata_s = (io_off_s == ADDR_W'(N_OUT + k)) ? sync2_q[k*DATA_W +: DATA_W] : rdata_s;
      end
    end
  end

  // Handshake FSM, response registers, output registers and input synchronisers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      a_q      <= '0;
      wd_q     <= '0;
      be_q     <= '0;
      rd_q     <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      io_out_q <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (bus.req) begin
            we_q <= bus.we;
            a_q  <= bus.a;
            wd_q <= bus.wd;
            be_q <= bus.be;
            if (WAIT > 0) begin
              state_q <= S_WAITING;
              cnt_q   <= 4'(WAIT - 1);
            end else begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              err_q   <= err_s;
              if (!err_s && !bus.we) rd_q <= rdata_s;
            end
          end
        end
        S_WAITING: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= err_s;
            if (!err_s && !we_q) rd_q <= rdata_s;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (commit_s && io_hit_s) begin
            for (int i = 0; i < N_OUT; i++) begin
              for (int j = 0; j < BE_W; j++) begin
                if (io_off_s == ADDR_W'(i) && be_q[j]) begin
                  io_out_q[i*DATA_W + j*8 +: 8] <= wd_q[j*8 +: 8];
                end
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port, committed on the edge that ends RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s && ram_hit_s) begin
      for (int j = 0; j < BE_W; j++) begin
        if (be_q[j]) ram_q[ram_idx_s][j*8 +: 8] <= wd_q[j*8 +: 8];
      end
    end
  end

  assign bus.rd    = rd_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign io_out    = io_out_q;
endmodule

// File: tb/tb_mem_map_ws.sv
// Directed self-checking bench for mem_map_ws: one instance with WAIT=1, one with WAIT=0.
module tb_mem_map_ws;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] io_out1, io_out0;
  logic [63:0]  io_in1, io_in0;
  int           n_cmp = 0;
  int           n_bad = 0;

  mem_map_ws_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  mem_map_ws_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();

  mem_map_ws #(.WAIT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1), .io_out(io_out1), .io_in(io_in1));
  mem_map_ws #(.WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0), .io_out(io_out0), .io_in(io_in0));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the WAIT=1 instance; lat counts negedges from request to ready.
  task automatic xact(input logic w, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] ben, output logic [31:0] rdat, output logic e,
                      output int lat);
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = w; bus1.a = addr; bus1.wd = data; bus1.be = ben;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus1.ready) begin
        lat = n;
        break;
      end
    end
    bus1.req = 1'b0; bus1.we = 1'b0;
    check_eq("xact_done", {127'd0, lat != 0}, 128'd1);
    rdat = bus1.rd;
    e    = bus1.err;
  endtask

  logic [31:0] r;
  logic        e;
  int          lat;

  initial begin
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.a = 32'd0; bus1.wd = 32'd0; bus1.be = 4'd0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.a = 32'd0; bus0.wd = 32'd0; bus0.be = 4'd0;
    io_in1 = 64'd0;
    io_in0 = {32'd0, 32'h0BAD_F00D};
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {127'd0, bus1.ready}, 128'd0);
    check_eq("rst_err", {127'd0, bus1.err}, 128'd0);
    check_eq("rst_rd", {96'd0, bus1.rd}, 128'd0);
    check_eq("rst_io_out", io_out1, 128'd0);
    reset = 1'b0;

    // Make rd and io_out non-zero so the mid-transaction reset has something to clear
    xact(1'b1, 32'h10, 32'h0, 4'hF, r, e, lat);
    xact(1'b1, 32'h1000, 32'h77, 4'hF, r, e, lat);
    xact(1'b0, 32'h1000, 32'h0, 4'h0, r, e, lat);
    check_eq("pre_rd", {96'd0, r}, {96'd0, 32'h77});

    @(negedge clk);
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.a = 32'h10; bus1.wd = 32'hDEAD_BEEF; bus1.be = 4'hF;
    @(negedge clk);
    reset = 1'b1; bus1.req = 1'b0; bus1.we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("midrst_ready", {127'd0, bus1.ready}, 128'd0);
    end
    check_eq("midrst_err", {127'd0, bus1.err}, 128'd0);
    check_eq("midrst_rd", {96'd0, bus1.rd}, 128'd0);
    check_eq("midrst_io_out", io_out1, 128'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("postrst_ready", {127'd0, bus1.ready}, 128'd0);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, r, e, lat);
    check_eq("midrst_ram", {96'd0, r}, 128'd0);

    xact(1'b1, 32'h10, 32'h1234_5678, 4'hF, r, e, lat);
    check_eq("wr_lat", lat, 128'd2);
    check_eq("wr_err", {127'd0, e}, 128'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, r, e, lat);
    check_eq("rd_lat", lat, 128'd2);
    check_eq("rd_data", {96'd0, r}, {96'd0, 32'h1234_5678});
    check_eq("rd_err", {127'd0, e}, 128'd0);

    xact(1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, r, e, lat);
    xact(1'b1, 32'h20, 32'h1122_3344, 4'b0101, r, e, lat);
    xact(1'b0, 32'h20, 32'h0, 4'h0, r, e, lat);
    check_eq("be_merge", {96'd0, r}, {96'd0, 32'hAA22_CC44});

    xact(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, r, e, lat);
    check_eq("be0_err", {127'd0, e}, 128'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, r, e, lat);
    check_eq("be0_noop", {96'd0, r}, {96'd0, 32'h1234_5678});

    xact(1'b1, 32'h1004, 32'h0000_00FF, 4'hF, r, e, lat);
    @(negedge clk);
    check_eq("io_out1", {96'd0, io_out1[63:32]}, {96'd0, 32'hFF});
    check_eq("io_out_rest", {io_out1[127:64], io_out1[31:0]}, 128'd0);
    xact(1'b0, 32'h1004, 32'h0, 4'h0, r, e, lat);
    check_eq("io_rdback", {96'd0, r}, {96'd0, 32'hFF});

    io_in1[31:0] = 32'h5A5A_5A5A;
    repeat (3) @(negedge clk);
    xact(1'b0, 32'h1010, 32'h0, 4'h0, r, e, lat);
    check_eq("io_in_rd", {96'd0, r}, {96'd0, 32'h5A5A_5A5A});
    check_eq("io_in_err", {127'd0, e}, 128'd0);

    xact(1'b0, 32'h2, 32'h0, 4'h0, r, e, lat);
    check_eq("mis_err", {127'd0, e}, 128'd1);
    check_eq("mis_rd", {96'd0, r}, {96'd0, 32'h5A5A_5A5A});
    xact(1'b0, 32'h800, 32'h0, 4'h0, r, e, lat);
    check_eq("unmap_err", {127'd0, e}, 128'd1);
    check_eq("unmap_rd", {96'd0, r}, {96'd0, 32'h5A5A_5A5A});
    xact(1'b1, 32'h1010, 32'h1357_9BDF, 4'hF, r, e, lat);
    check_eq("wr_in_err", {127'd0, e}, 128'd1);
    @(negedge clk);
    check_eq("wr_in_io_out", io_out1, {64'd0, 32'hFF, 32'd0});
    xact(1'b0, 32'h1010, 32'h0, 4'h0, r, e, lat);
    check_eq("wr_in_noeffect", {96'd0, r}, {96'd0, 32'h5A5A_5A5A});

    // WAIT=0, req held high: accept, RESP, IDLE, accept, ...
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.a = 32'h1010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("b2b_ready", {127'd0, bus0.ready}, {127'd0, (i % 2) == 0});
      if (i % 2 == 0) check_eq("b2b_rd", {96'd0, bus0.rd}, {96'd0, 32'h0BAD_F00D});
    end
    bus0.req = 1'b0;
    @(negedge clk);
    check_eq("b2b_idle", {127'd0, bus0.ready}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
